// File: rtl/ninjin_pkg.sv
// Shared ninjin buffer-protocol constants, command encodings and the
// DDR responder state type.
package ninjin_pkg;

    localparam int MEMSIZE = 8;
    localparam int LSB     = 2;
    localparam int DWIDTH  = 16;
    localparam int BWIDTH  = 2 * DWIDTH;
    localparam int LWIDTH  = 8;

    localparam logic DDR_READ  = 1'b0;
    localparam logic DDR_WRITE = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } ddr_resp_state_t;

endpackage

// File: rtl/ninjin_ddr_resp_slot.sv
// One pending-command register: capture, overrun detect and free.
// The slot stays occupied from capture until the responder frees it.
module ninjin_ddr_resp_slot
    import ninjin_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               capture,
    input  logic               free,
    input  logic [MEMSIZE-1:0] cap_base,
    input  logic [LWIDTH-1:0]  cap_len,
    output logic               pending,
    output logic [MEMSIZE-1:0] base,
    output logic [LWIDTH-1:0]  len,
    output logic               drop
);

    // Freeing wins over occupancy, so a capture in the freeing cycle is accepted.
    assign drop = capture && pending && !free;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            base    <= '0;
            len     <= '0;
        end else if (capture && !drop) begin
            pending <= 1'b1;
            base    <= cap_base;
            len     <= cap_len;
        end else if (free) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/ninjin_ddr_resp.sv
// DDR-side responder: executes buffer fill (READ) and drain (WRITE) commands
// against a word-addressed backing memory with a one-stage data pipeline.
module ninjin_ddr_resp
    import ninjin_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ddr_req,
    input  logic                   ddr_mode,
    input  logic [MEMSIZE+LSB-1:0] ddr_base,
    input  logic [LWIDTH-1:0]      ddr_len,
    output logic                   ddr_we,
    output logic [MEMSIZE-1:0]     ddr_waddr,
    output logic [BWIDTH-1:0]      ddr_wdata,
    output logic [MEMSIZE-1:0]     ddr_raddr,
    input  logic [BWIDTH-1:0]      ddr_rdata,
    output logic                   ext_we,
    output logic [MEMSIZE-1:0]     ext_addr,
    output logic [BWIDTH-1:0]      ext_wdata,
    input  logic [BWIDTH-1:0]      ext_rdata,
    output logic                   busy,
    output logic                   done,
    output logic                   err_overrun
);

    ddr_resp_state_t state, state_next;

    logic               rd_pending, wr_pending, rd_drop, wr_drop;
    logic [MEMSIZE-1:0] rd_base, wr_base, act_base, offset, issue_addr;
    logic [LWIDTH-1:0]  rd_len, wr_len, act_len, cnt;
    logic               cur_mode, sel_mode;
    logic               start, advance, finish, issue, last_issue, pipe_last;

    ninjin_ddr_resp_slot u_rd_slot (
        .clk      (clk),
        .rst      (rst),
        .capture  (ddr_req && ddr_mode == DDR_READ),
        .free     (finish && cur_mode == DDR_READ),
        .cap_base (ddr_base[MEMSIZE+LSB-1:LSB]),
        .cap_len  (ddr_len),
        .pending  (rd_pending),
        .base     (rd_base),
        .len      (rd_len),
        .drop     (rd_drop)
    );

    ninjin_ddr_resp_slot u_wr_slot (
        .clk      (clk),
        .rst      (rst),
        .capture  (ddr_req && ddr_mode == DDR_WRITE),
        .free     (finish && cur_mode == DDR_WRITE),
        .cap_base (ddr_base[MEMSIZE+LSB-1:LSB]),
        .cap_len  (ddr_len),
        .pending  (wr_pending),
        .base     (wr_base),
        .len      (wr_len),
        .drop     (wr_drop)
    );

    // NOTE: every signal written here gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    always_comb begin
        state_next = state;
        sel_mode   = cur_mode;
        start      = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (rd_pending) begin
                    start      = 1'b1;
                    sel_mode   = DDR_READ;
                    state_next = (rd_len == '0) ? S_DONE : S_RD;
                end else if (wr_pending) begin
                    start      = 1'b1;
                    sel_mode   = DDR_WRITE;
                    state_next = (wr_len == '0) ? S_DONE : S_WR;
                end
            end
            S_RD, S_WR: begin
                if (cnt == act_len) state_next = S_DONE;
                else                advance    = 1'b1;
            end
            S_DONE: begin
                if (pipe_last) begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign act_base   = (sel_mode == DDR_READ) ? rd_base : wr_base;
    assign act_len    = (sel_mode == DDR_READ) ? rd_len  : wr_len;
    assign offset     = start ? '0 : MEMSIZE'(cnt);
    assign issue_addr = act_base + offset;
    assign issue      = (start && act_len != '0) || advance;
    assign last_issue = (state == S_RD || state == S_WR) && cnt == act_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_mode    <= DDR_READ;
            cnt         <= '0;
            pipe_last   <= 1'b0;
            ddr_we      <= 1'b0;
            ext_we      <= 1'b0;
            ddr_waddr   <= '0;
            ddr_raddr   <= '0;
            ext_addr    <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (start) begin
                cur_mode <= sel_mode;
                cnt      <= LWIDTH'(1);
            end else if (advance) begin
                cnt <= cnt + LWIDTH'(1);
            end
            // A zero-length command spends one extra S_DONE cycle so its done
            // pulse lands where a one-beat command's would.
            pipe_last <= last_issue || (state == S_DONE && !pipe_last);
            ddr_we    <= (state == S_RD);
            ext_we    <= (state == S_WR);
            if (state == S_RD) ddr_waddr <= ext_addr;
            if (state == S_WR)                            ext_addr  <= ddr_raddr;
            else if (issue && sel_mode == DDR_READ)       ext_addr  <= issue_addr;
            if (issue && sel_mode == DDR_WRITE)           ddr_raddr <= issue_addr;
            if (rd_drop || wr_drop) err_overrun <= 1'b1;
        end
    end

    assign ddr_wdata = ddr_we ? ext_rdata : '0;
    assign ext_wdata = ext_we ? ddr_rdata : '0;
    assign done      = (state == S_DONE) && pipe_last;
    assign busy      = rd_pending || wr_pending;

endmodule
